fp_add_seq: RTL and testbench

//  Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor,

---
 rtl/fp_add_seq.sv | 250 +++++++++++++++++++++++++
 tb/tb_fp_add_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_seq.sv
// Multi-cycle IEEE-754-style floating-point adder/subtractor with chunked carry mantissa add.
// Operands are aligned, summed CHUNK_W bits per cycle, then normalised and rounded (RNE).
module fp_add_seq #(
  parameter int unsigned EXP_W   = 11,
  parameter int unsigned MAN_W   = 52,
  parameter int unsigned CHUNK_W = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   sub_i,
  input  logic [EXP_W+MAN_W:0]   op_a_i,
  input  logic [EXP_W+MAN_W:0]   op_b_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [EXP_W+MAN_W:0]   result_o,
  output logic                   ovf_o,
  output logic                   inexact_o
);

  localparam int unsigned FW     = 1 + EXP_W + MAN_W;
  localparam int unsigned W      = MAN_W + 4;
  localparam int unsigned NCHUNK = (W + CHUNK_W - 1) / CHUNK_W;
  localparam int unsigned DW     = NCHUNK * CHUNK_W;
  localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);
  localparam int unsigned XW     = EXP_W + 2;

  localparam logic [EXP_W-1:0]     EXP_ONES  = '1;
  localparam logic [EXP_W-1:0]     FAR_SHIFT = EXP_W'(MAN_W + 3);
  localparam logic signed [XW-1:0] EXP_MAX   = {2'b00, EXP_ONES};
  localparam logic signed [XW-1:0] ONE_X     = XW'(1);
  localparam logic [FW-1:0]        NAN_VAL   = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound} state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   sub_q;
  logic [FW-1:0]          opa_q, opb_q;
  logic [DW-1:0]          man_a_q, man_b_q, sum_q;
  logic                   carry_q;
  logic signed [XW-1:0]   exp_q;
  logic                   sign_q, eff_sub_q, special_q;
  logic [FW-1:0]          special_val_q;
  logic                   busy_q, done_q, ovf_q, inexact_q;
  logic [FW-1:0]          result_q;

  // Leading-zero count; W when the vector is all zero.
  function automatic logic [XW-1:0] lzc(input logic [W-1:0] v);
    logic [XW-1:0] n;
    n = XW'(W);
    for (int i = 0; i < W; i++) begin
      if (v[i]) n = XW'(W - 1 - i);
    end
    return n;
  endfunction

  // Alignment and special-value decode
  logic                     sa, sb, sl, ss, a_nan, b_nan, a_inf, b_inf, swap, lost;
  logic [EXP_W-1:0]         ea, eb, el, es, d;
  logic [MAN_W-1:0]         fa, fb, fl, fs;
  logic [EXP_W+MAN_W-1:0]   key_a, key_b;
  logic [W-1:0]             ml, ms, ms_al;
  logic                     al_special;
  logic [FW-1:0]            al_special_val;

  always_comb begin
    sa = opa_q[FW-1];
    ea = opa_q[FW-2 -: EXP_W];
    fa = opa_q[MAN_W-1:0];
    sb = opb_q[FW-1] ^ sub_q;
    eb = opb_q[FW-2 -: EXP_W];
    fb = opb_q[MAN_W-1:0];
    a_nan = (ea == EXP_ONES) && (fa != '0);
    b_nan = (eb == EXP_ONES) && (fb != '0);
    a_inf = (ea == EXP_ONES) && (fa == '0);
    b_inf = (eb == EXP_ONES) && (fb == '0);
    // Subnormals compare and add as zero.
    key_a = (ea == '0) ? '0 : {ea, fa};
    key_b = (eb == '0) ? '0 : {eb, fb};
    swap  = key_b > key_a;
    el = swap ? eb : ea;
    es = swap ? ea : eb;
    fl = swap ? fb : fa;
    fs = swap ? fa : fb;
    sl = swap ? sb : sa;
    ss = swap ? sa : sb;
    ml = (el == '0) ? '0 : {1'b1, fl, 3'b000};
    ms = (es == '0) ? '0 : {1'b1, fs, 3'b000};
    d  = el - es;
    if (d >= FAR_SHIFT) begin
      ms_al = '0;
      lost  = |ms;
    end else begin
      ms_al = ms >> d;
      lost  = |(ms & ~({W{1'b1}} << d));
    end
    ms_al[0] = ms_al[0] | lost;

    al_special     = 1'b1;
    al_special_val = NAN_VAL;
    if (a_nan || b_nan) begin
      al_special_val = NAN_VAL;
    end else if (a_inf && b_inf) begin
      al_special_val = (sa != sb) ? NAN_VAL : {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (a_inf) begin
      al_special_val = {sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      al_special_val = {sb, EXP_ONES, {MAN_W{1'b0}}};
    end else begin
      al_special = 1'b0;
    end
  end

  // One mantissa chunk per cycle, LSB chunk first
  logic [DW-1:0]      b_eff;
  logic [CHUNK_W:0]   chunk_sum;

  always_comb begin
    b_eff     = man_b_q ^ {DW{eff_sub_q}};
    chunk_sum = {1'b0, man_a_q[int'(cnt_q) * CHUNK_W +: CHUNK_W]}
              + {1'b0, b_eff[int'(cnt_q) * CHUNK_W +: CHUNK_W]}
              + (CHUNK_W + 1)'(carry_q);
  end

  // Normalise and round share the NORM cycle so the registered result is out during ROUND.
  logic [DW:0]            full;
  logic [W-1:0]           m_n;
  logic signed [XW-1:0]   e_n, e_r, lz;
  logic                   zero_n, up, ovf_r, inx_r;
  logic [MAN_W+1:0]       mr;
  logic [MAN_W-1:0]       frac_r;
  logic [FW-1:0]          res_r;

  always_comb begin
    full   = {carry_q, sum_q};
    lz     = $signed(lzc(full[W-1:0]));
    zero_n = 1'b0;
    if (!eff_sub_q) begin
      if (full[W]) begin
        m_n = full[W:1] | W'(full[0]);
        e_n = exp_q + ONE_X;
      end else begin
        m_n = full[W-1:0];
        e_n = exp_q;
      end
    end else begin
      m_n = full[W-1:0] << lz;
      e_n = exp_q - lz;
      if (lz >= exp_q) zero_n = 1'b1;
    end
    if (m_n == '0) zero_n = 1'b1;

    up = m_n[2] & (m_n[1] | m_n[0] | m_n[3]);
    mr = {1'b0, m_n[W-1:3]} + (MAN_W + 2)'(up);
    if (mr[MAN_W+1]) begin
      e_r    = e_n + ONE_X;
      frac_r = mr[MAN_W:1];
    end else begin
      e_r    = e_n;
      frac_r = mr[MAN_W-1:0];
    end

    inx_r = |m_n[2:0];
    ovf_r = 1'b0;
    if (special_q) begin
      res_r = special_val_q;
      inx_r = 1'b0;
    end else if (zero_n) begin
      res_r = '0;
    end else if (e_r >= EXP_MAX) begin
      res_r = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      ovf_r = 1'b1;
    end else begin
      res_r = {sign_q, e_r[EXP_W-1:0], frac_r};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      sub_q         <= 1'b0;
      opa_q         <= '0;
      opb_q         <= '0;
      man_a_q       <= '0;
      man_b_q       <= '0;
      sum_q         <= '0;
      carry_q       <= 1'b0;
      exp_q         <= '0;
      sign_q        <= 1'b0;
      eff_sub_q     <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      ovf_q         <= 1'b0;
      inexact_q     <= 1'b0;
      result_q      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            opa_q   <= op_a_i;
            opb_q   <= op_b_i;
            sub_q   <= sub_i;
            busy_q  <= 1'b1;
            state_q <= StAlign;
          end
        end
        StAlign: begin
          man_a_q       <= DW'(ml);
          man_b_q       <= DW'(ms_al);
          exp_q         <= XW'(el);
          sign_q        <= sl;
          eff_sub_q     <= sl ^ ss;
          carry_q       <= sl ^ ss;
          cnt_q         <= '0;
          special_q     <= al_special;
          special_val_q <= al_special_val;
          state_q       <= StAdd;
        end
        StAdd: begin
          sum_q[int'(cnt_q) * CHUNK_W +: CHUNK_W] <= chunk_sum[CHUNK_W-1:0];
          carry_q <= chunk_sum[CHUNK_W];
          if (cnt_q == CNT_W'(NCHUNK - 1)) state_q <= StNorm;
          else cnt_q <= cnt_q + 1'b1;
        end
        StNorm: begin
          result_q  <= res_r;
          ovf_q     <= ovf_r;
          inexact_q <= inx_r;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= StRound;
        end
        StRound: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign result_o  = result_q;
  assign ovf_o     = ovf_q;
  assign inexact_o = inexact_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: default build (CHUNK_W=14) and a CHUNK_W=8 build side by side.
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start8, sub;
  logic [63:0] op_a, op_b;
  logic        busy, done, ovf, inexact;
  logic [63:0] result;
  logic        busy8, done8, ovf8, inexact8;
  logic [63:0] result8;

  int          n_chk = 0;
  int          n_pass = 0;
  int          lat, busy_cyc, done_cnt;
  logic [63:0] r_res;
  logic        r_ovf, r_inx;

  always #5 clk = ~clk;

  fp_add_seq u_dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start),
    .sub_i     (sub),
    .op_a_i    (op_a),
    .op_b_i    (op_b),
    .busy_o    (busy),
    .done_o    (done),
    .result_o  (result),
    .ovf_o     (ovf),
    .inexact_o (inexact)
  );

  fp_add_seq #(.CHUNK_W(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start8),
    .sub_i     (sub),
    .op_a_i    (op_a),
    .op_b_i    (op_b),
    .busy_o    (busy8),
    .done_o    (done8),
    .result_o  (result8),
    .ovf_o     (ovf8),
    .inexact_o (inexact8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, want);
  endtask

  // Launch one op with start held for `hold` cycles; latency counts edges from the accepting one.
  task automatic run_op(input bit use8, input logic [63:0] a, input logic [63:0] b,
                        input logic s, input int hold, input int trail);
    bit seen = 1'b0;
    @(negedge clk);
    op_a = a;
    op_b = b;
    sub  = s;
    if (use8) start8 = 1'b1;
    else start = 1'b1;
    lat = 0;
    busy_cyc = 0;
    done_cnt = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat >= hold) begin
        start  = 1'b0;
        start8 = 1'b0;
      end
      if (use8 ? busy8 : busy) busy_cyc++;
      if (use8 ? done8 : done) begin
        seen = 1'b1;
        done_cnt++;
        r_res = use8 ? result8 : result;
        r_ovf = use8 ? ovf8 : ovf;
        r_inx = use8 ? inexact8 : inexact;
      end
    end
    start  = 1'b0;
    start8 = 1'b0;
    if (!seen) lat = -1;
    for (int i = 0; i < trail; i++) begin
      @(posedge clk);
      #1;
      if (use8 ? busy8 : busy) busy_cyc++;
      if (use8 ? done8 : done) done_cnt++;
    end
  endtask

  task automatic vec(input string tag, input logic [63:0] a, input logic [63:0] b, input logic s,
                     input logic [63:0] want, input logic want_ovf, input logic want_inx);
    run_op(1'b0, a, b, s, 1, 1);
    check({tag, " result"}, r_res, want);
    check({tag, " ovf"}, 64'(r_ovf), 64'(want_ovf));
    check({tag, " inexact"}, 64'(r_inx), 64'(want_inx));
  endtask

  task automatic reset_mid_op(input bit use8, input string tag);
    @(negedge clk);
    op_a = 64'h4008000000000000;
    op_b = 64'h3FE0000000000000;
    sub  = 1'b1;
    if (use8) start8 = 1'b1;
    else start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start8 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check({tag, " rst busy"}, 64'(use8 ? busy8 : busy), 64'd0);
    check({tag, " rst done"}, 64'(use8 ? done8 : done), 64'd0);
    check({tag, " rst result"}, use8 ? result8 : result, 64'd0);
    check({tag, " rst ovf"}, 64'(use8 ? ovf8 : ovf), 64'd0);
    check({tag, " rst inexact"}, 64'(use8 ? inexact8 : inexact), 64'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start8 = 1'b0;
    sub    = 1'b0;
    op_a   = '0;
    op_b   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset result", result, 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    check("reset inexact", 64'(inexact), 64'd0);
    check("reset result8", result8, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1.0 + 1.0, with timing
    run_op(1'b0, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 1, 3);
    check("1+1 latency", 64'(lat), 64'd7);
    check("1+1 busy cycles", 64'(busy_cyc), 64'd6);
    check("1+1 done pulses", 64'(done_cnt), 64'd1);
    check("1+1 result", r_res, 64'h4000000000000000);
    check("1+1 ovf", 64'(r_ovf), 64'd0);
    check("1+1 inexact", 64'(r_inx), 64'd0);

    vec("3-0.5", 64'h4008000000000000, 64'h3FE0000000000000, 1'b1, 64'h4004000000000000, 0, 0);
    vec("3-3", 64'h4008000000000000, 64'h4008000000000000, 1'b1, 64'h0000000000000000, 0, 0);
    vec("1+(-1)", 64'h3FF0000000000000, 64'hBFF0000000000000, 1'b0, 64'h0, 0, 0);
    vec("-2+1", 64'hC000000000000000, 64'h3FF0000000000000, 1'b0, 64'hBFF0000000000000, 0, 0);
    vec("tie even", 64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000000, 0, 1);
    vec("tie odd", 64'h3FF0000000000001, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000002, 0, 1);
    vec("rnd carry", 64'h3FFFFFFFFFFFFFFF, 64'h3CA0000000000000, 1'b0, 64'h4000000000000000, 0, 1);
    vec("far sticky", 64'h3FF0000000000000, 64'h0010000000000000, 1'b0, 64'h3FF0000000000000, 0, 1);
    vec("overflow", 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, 64'h7FF0000000000000, 1, 0);
    vec("inf-inf", 64'h7FF0000000000000, 64'h7FF0000000000000, 1'b1, 64'h7FF8000000000000, 0, 0);
    vec("nan in", 64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, 64'h7FF8000000000000, 0, 0);
    vec("inf+1", 64'h7FF0000000000000, 64'h3FF0000000000000, 1'b0, 64'h7FF0000000000000, 0, 0);
    vec("1-inf", 64'h3FF0000000000000, 64'h7FF0000000000000, 1'b1, 64'hFFF0000000000000, 0, 0);
    vec("subnorm", 64'h0000000000000001, 64'h0000000000000001, 1'b0, 64'h0000000000000000, 0, 0);

    // start held 3 cycles: one op only, then back-to-back start the cycle after done
    run_op(1'b0, 64'h4008000000000000, 64'h3FE0000000000000, 1'b1, 3, 0);
    check("hold latency", 64'(lat), 64'd7);
    check("hold busy cycles", 64'(busy_cyc), 64'd6);
    check("hold result", r_res, 64'h4004000000000000);
    @(posedge clk);
    run_op(1'b0, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 1, 4);
    check("b2b latency", 64'(lat), 64'd7);
    check("b2b result", r_res, 64'h4000000000000000);
    check("hold+b2b done pulses", 64'(done_cnt), 64'd1);
    check("b2b busy cycles", 64'(busy_cyc), 64'd6);

    reset_mid_op(1'b0, "w14");
    run_op(1'b0, 64'h3FF0000000000001, 64'h3CA0000000000000, 1'b0, 1, 1);
    check("post-rst latency", 64'(lat), 64'd7);
    check("post-rst result", r_res, 64'h3FF0000000000002);

    // CHUNK_W=8 build: NCHUNK=7, latency 10
    run_op(1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, 1, 3);
    check("w8 latency", 64'(lat), 64'd10);
    check("w8 busy cycles", 64'(busy_cyc), 64'd9);
    check("w8 done pulses", 64'(done_cnt), 64'd1);
    check("w8 result", r_res, 64'h4000000000000000);
    run_op(1'b1, 64'h4008000000000000, 64'h3FE0000000000000, 1'b1, 1, 1);
    check("w8 3-0.5", r_res, 64'h4004000000000000);
    reset_mid_op(1'b1, "w8");
    run_op(1'b1, 64'h3FF0000000000001, 64'h3CA0000000000000, 1'b0, 1, 1);
    check("w8 post-rst latency", 64'(lat), 64'd10);
    check("w8 post-rst result", r_res, 64'h3FF0000000000002);
    check("w8 post-rst inexact", 64'(r_inx), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
